// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer: FSM state codes and a
// counter-width helper.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  // Bits needed to hold any value in 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_debounce_pulse_if.sv
// Button signal bundle: raw input towards the conditioner, clean pulse and
// debounced level back out.
interface button_debounce_pulse_if;
  logic button_raw;
  logic button_pulse;
  logic button_level;

  modport master (output button_raw, input button_pulse, input button_level);
  modport slave  (input button_raw, output button_pulse, output button_level);
endinterface

// File: rtl/sync_chain.sv
// N-flop synchroniser for a single asynchronous input, cleared to 0 by an
// asynchronous active-high reset. STAGES must be at least 2.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/button_debounce_pulse.sv
// Push-button conditioner: synchronise, debounce, and emit one clean pulse per
// press. Define AUTO_REPEAT_EN to add held-button auto-repeat pulses.
module button_debounce_pulse
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  button_debounce_pulse_if.slave  bus
);

  localparam int             CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             press_accept;
  logic             s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (reset),
    .d_i (bus.button_raw),
    .q_o (s)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    press_accept = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = PRESSED;
          cnt_d        = '0;
          press_accept = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      PRESSED: begin
        cnt_d = '0;
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to high resumes PRESSED without a fresh pulse.
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = cnt_width(REP_MAX);

  logic [REP_W-1:0] rep_q, rep_d, rep_inc, rep_target;
  logic             rep_armed_q, rep_armed_d;
  logic             rep_fire;

  // First repeat waits REPEAT_DELAY cycles; once armed, every REPEAT_PERIOD.
  always_comb begin
    rep_d       = rep_q;
    rep_armed_d = rep_armed_q;
    rep_fire    = 1'b0;
    rep_inc     = rep_q + REP_W'(1);
    rep_target  = rep_armed_q ? REP_W'(REPEAT_PERIOD) : REP_W'(REPEAT_DELAY);
    if ((state_q == PRESSED) && s) begin
      if (rep_inc == rep_target) begin
        rep_fire    = 1'b1;
        rep_d       = '0;
        rep_armed_d = 1'b1;
      end else begin
        rep_d = rep_inc;
      end
    end else if (state_q != RELEASE_WAIT) begin
      rep_d       = '0;
      rep_armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_q       <= '0;
      rep_armed_q <= 1'b0;
    end else begin
      rep_q       <= rep_d;
      rep_armed_q <= rep_armed_d;
    end
  end

  assign pulse_d = press_accept | rep_fire;
`else
  assign pulse_d = press_accept;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign bus.button_pulse = pulse_q;
  assign bus.button_level = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Bench for button_debounce_pulse: directed scenarios plus random bouncing,
// checked against a run-length debounce model. Honours AUTO_REPEAT_EN.
module tb_button_debounce_pulse;
  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;
`ifdef AUTO_REPEAT_EN
  localparam int REPEAT_DELAY    = 16;
  localparam int REPEAT_PERIOD   = 8;
`endif

  logic clk;
  logic reset;

  button_debounce_pulse_if bif ();

  button_debounce_pulse #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef AUTO_REPEAT_EN
    ,
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   vectors;
  int   miscompares;

  // Reference model: the raw samples seen SYNC_STAGES edges ago, a level, and
  // the length of the current run of samples that disagree with that level.
  logic hist [SYNC_STAGES];
  logic m_lvl;
  int   m_run;
  int   m_hold;
  logic exp_pulse;
  logic exp_level;

  task automatic model_reset();
    for (int i = 0; i < SYNC_STAGES; i++) hist[i] = 1'b0;
    m_lvl     = 1'b0;
    m_run     = 0;
    m_hold    = 0;
    exp_pulse = 1'b0;
    exp_level = 1'b0;
  endtask

  task automatic model_step(input logic v);
    logic s_used;
    s_used = hist[SYNC_STAGES-1];
    for (int i = SYNC_STAGES - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0]   = v;
    exp_pulse = 1'b0;
    if (s_used != m_lvl) begin
      m_run++;
      if (m_run == DEBOUNCE_CYCLES) begin
        m_lvl     = s_used;
        m_run     = 0;
        m_hold    = 0;
        exp_pulse = s_used;
      end
    end else begin
      if (m_lvl && m_run == 0) begin
        m_hold++;
`ifdef AUTO_REPEAT_EN
        if (m_hold == REPEAT_DELAY ||
            (m_hold > REPEAT_DELAY && (m_hold - REPEAT_DELAY) % REPEAT_PERIOD == 0))
          exp_pulse = 1'b1;
`endif
      end
      m_run = 0;
    end
    exp_level = m_lvl;
  endtask

  // Apply one raw value for one clock and advance the model; outputs are
  // stable for sampling when this returns.
  task automatic step(input logic v);
    @(negedge clk);
    bif.button_raw = v;
    @(posedge clk);
    model_step(v);
    #1;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    bif.button_raw = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (bif.button_pulse !== 1'b0 || bif.button_level !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: pulse=%b level=%b, required 0/0", bif.button_pulse, bif.button_level);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0);
      vectors++;
      if (bif.button_pulse !== exp_pulse || bif.button_level !== exp_level) begin
        miscompares++;
        $display("FAIL reset_idle[%0d]: pulse=%b level=%b, required %b/%b",
                 i, bif.button_pulse, bif.button_level, exp_pulse, exp_level);
      end
    end
  endtask

  task automatic test_press();
    int npulse, first_at;
    npulse = 0; first_at = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      vectors++;
      if (bif.button_pulse !== exp_pulse || bif.button_level !== exp_level) begin
        miscompares++;
        $display("FAIL press[%0d]: pulse=%b level=%b, required %b/%b",
                 i, bif.button_pulse, bif.button_level, exp_pulse, exp_level);
      end
      if (bif.button_pulse === 1'b1) begin
        npulse++;
        if (first_at < 0) first_at = i;
      end
    end
    vectors++;
    if (npulse != 1 || first_at != SYNC_STAGES + DEBOUNCE_CYCLES - 1) begin
      miscompares++;
      $display("FAIL press_latency: pulses=%0d first_edge=%0d, required 1 at %0d",
               npulse, first_at, SYNC_STAGES + DEBOUNCE_CYCLES - 1);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0);
      vectors++;
      if (bif.button_pulse !== exp_pulse || bif.button_level !== exp_level) begin
        miscompares++;
        $display("FAIL press_release[%0d]: pulse=%b level=%b, required %b/%b",
                 i, bif.button_pulse, bif.button_level, exp_pulse, exp_level);
      end
    end
  endtask

  task automatic test_glitch();
    int seen_hi;
    seen_hi = 0;
    for (int i = 0; i < 10; i++) begin
      step(i < 3);
      vectors++;
      if (bif.button_pulse !== exp_pulse || bif.button_level !== exp_level) begin
        miscompares++;
        $display("FAIL glitch[%0d]: pulse=%b level=%b, required %b/%b",
                 i, bif.button_pulse, bif.button_level, exp_pulse, exp_level);
      end
      if (bif.button_pulse !== 1'b0 || bif.button_level !== 1'b0) seen_hi++;
    end
    vectors++;
    if (seen_hi != 0) begin
      miscompares++;
      $display("FAIL glitch_quiet: active_cycles=%0d, required 0", seen_hi);
    end
  endtask

  task automatic test_release_bounce();
    int npulse, level_drop;
    logic v;
    npulse = 0; level_drop = 0;
    // 8 high, 2 low bounce, 5 high, then a 6-cycle release.
    for (int i = 0; i < 21; i++) begin
      v = (i < 8) || (i >= 10 && i < 15);
      step(v);
      vectors++;
      if (bif.button_pulse !== exp_pulse || bif.button_level !== exp_level) begin
        miscompares++;
        $display("FAIL bounce[%0d]: pulse=%b level=%b, required %b/%b",
                 i, bif.button_pulse, bif.button_level, exp_pulse, exp_level);
      end
      if (bif.button_pulse === 1'b1) npulse++;
      if (i >= 5 && i < 15 && bif.button_level !== 1'b1) level_drop++;
    end
    vectors++;
    if (npulse != 1 || level_drop != 0 || bif.button_level !== 1'b0) begin
      miscompares++;
      $display("FAIL bounce_summary: pulses=%0d level_drops=%0d final_level=%b, required 1/0/0",
               npulse, level_drop, bif.button_level);
    end
  endtask

  task automatic test_reset_mid_press();
    int npulse, first_at;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      vectors++;
      if (bif.button_pulse !== exp_pulse || bif.button_level !== exp_level) begin
        miscompares++;
        $display("FAIL midrst_pre[%0d]: pulse=%b level=%b, required %b/%b",
                 i, bif.button_pulse, bif.button_level, exp_pulse, exp_level);
      end
    end
    #2 reset = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (bif.button_pulse !== 1'b0 || bif.button_level !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_async: pulse=%b level=%b, required 0/0", bif.button_pulse, bif.button_level);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    npulse = 0; first_at = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      vectors++;
      if (bif.button_pulse !== exp_pulse || bif.button_level !== exp_level) begin
        miscompares++;
        $display("FAIL midrst_post[%0d]: pulse=%b level=%b, required %b/%b",
                 i, bif.button_pulse, bif.button_level, exp_pulse, exp_level);
      end
      if (bif.button_pulse === 1'b1) begin
        npulse++;
        if (first_at < 0) first_at = i;
      end
    end
    vectors++;
    if (npulse != 1 || first_at != SYNC_STAGES + DEBOUNCE_CYCLES - 1) begin
      miscompares++;
      $display("FAIL midrst_latency: pulses=%0d first_edge=%0d, required 1 at %0d",
               npulse, first_at, SYNC_STAGES + DEBOUNCE_CYCLES - 1);
    end
    for (int i = 0; i < 8; i++) step(1'b0);
  endtask

  task automatic test_long_hold();
    int npulse, want;
`ifdef AUTO_REPEAT_EN
    want = 4;
`else
    want = 1;
`endif
    npulse = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1);
      vectors++;
      if (bif.button_pulse !== exp_pulse || bif.button_level !== exp_level) begin
        miscompares++;
        $display("FAIL hold[%0d]: pulse=%b level=%b, required %b/%b",
                 i, bif.button_pulse, bif.button_level, exp_pulse, exp_level);
      end
      if (bif.button_pulse === 1'b1) npulse++;
    end
    vectors++;
    if (npulse != want) begin
      miscompares++;
      $display("FAIL hold_pulses: got %0d, required %0d", npulse, want);
    end
    for (int i = 0; i < 8; i++) step(1'b0);
  endtask

  task automatic test_random_bounce();
    logic v;
    int   len;
    for (int r = 0; r < 80; r++) begin
      v   = 1'($urandom_range(0, 1));
      len = (r % 4 == 0) ? $urandom_range(5, 30) : $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        step(v);
        vectors++;
        if (bif.button_pulse !== exp_pulse || bif.button_level !== exp_level) begin
          miscompares++;
          $display("FAIL random[%0d.%0d]: pulse=%b level=%b, required %b/%b",
                   r, i, bif.button_pulse, bif.button_level, exp_pulse, exp_level);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0);
      vectors++;
      if (bif.button_pulse !== exp_pulse || bif.button_level !== exp_level) begin
        miscompares++;
        $display("FAIL random_tail[%0d]: pulse=%b level=%b, required %b/%b",
                 i, bif.button_pulse, bif.button_level, exp_pulse, exp_level);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_press();
    test_glitch();
    test_release_bounce();
    test_reset_mid_press();
    test_long_hold();
    test_random_bounce();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
